host_byte_bridge: RTL

Byte-serial host front end for `main_core_serialCmd`. Parses a framed host byte stream into core commands (`cmd`/`cmd_hasAny`/`cmd_consume`) and 64-bit input words (`in`/`in_isReady`/`in_canReceive`). Serializes core output words (`out`/`out_isReady`/`out_canReceive`) back to host bytes on request. It is the stage directly upstream and downstream of the core, and the top level connects it between the host link and the core.

---
 rtl/host_byte_bridge.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/host_byte_bridge.sv
// Byte-serial host front end: parses framed host bytes into core commands and
// 64-bit data words, and serializes core output words back to the host.
module host_byte_bridge #(
  parameter int CMD_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       hin,
  input  logic             hin_isReady,
  output logic             hin_canReceive,
  output logic [7:0]       hout,
  output logic             hout_isReady,
  input  logic             hout_canReceive,
  output logic [CMD_W-1:0] cmd,
  output logic             cmd_hasAny,
  input  logic             cmd_consume,
  output logic [63:0]      in,
  output logic             in_isReady,
  input  logic             in_canReceive,
  input  logic [63:0]      out,
  input  logic             out_isReady,
  output logic             out_canReceive
);

  typedef enum logic [2:0] {
    RX_IDLE, RX_CMD_B0, RX_CMD_B1, RX_CMD_WAIT, RX_DATA_B, RX_DATA_WAIT, RX_RD_ARM
  } rx_state_e;

  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_e;

  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] cmd_q, cmd_d;
  logic [63:0] word_q, word_d;
  logic [2:0]  rx_bcnt_q, rx_bcnt_d;
  logic [6:0]  wcnt_q, wcnt_d;
  logic [6:0]  rd_n_q, rd_n_d;
  logic        tcnt_load;

  tx_state_e   tx_state_q, tx_state_d;
  logic [63:0] sr_q, sr_d;
  logic [3:0]  bcnt_q, bcnt_d;
  logic [6:0]  tcnt_q, tcnt_d;

  // RX: header decode, payload assembly and the core-side hold states.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    rx_state_d     = rx_state_q;
    cmd_d          = cmd_q;
    word_d         = word_q;
    rx_bcnt_d      = rx_bcnt_q;
    wcnt_d         = wcnt_q;
    rd_n_d         = rd_n_q;
    tcnt_load      = 1'b0;
    hin_canReceive = 1'b0;
    cmd_hasAny     = 1'b0;
    in_isReady     = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        hin_canReceive = 1'b1;
        if (hin_isReady) begin
          unique case (hin[7:6])
            2'b00: rx_state_d = RX_CMD_B0;
            2'b01: begin
              wcnt_d     = {1'b0, hin[5:0]} + 7'd1;
              rx_bcnt_d  = 3'd0;
              rx_state_d = RX_DATA_B;
            end
            2'b10: begin
              rd_n_d     = {1'b0, hin[5:0]} + 7'd1;
              rx_state_d = RX_RD_ARM;
            end
            default: ;
          endcase
        end
      end
      RX_CMD_B0: begin
        hin_canReceive = 1'b1;
        if (hin_isReady) begin
          cmd_d[7:0] = hin;
          rx_state_d = RX_CMD_B1;
        end
      end
      RX_CMD_B1: begin
        hin_canReceive = 1'b1;
        if (hin_isReady) begin
          cmd_d[15:8] = hin;
          rx_state_d  = RX_CMD_WAIT;
        end
      end
      RX_CMD_WAIT: begin
        cmd_hasAny = 1'b1;
        if (cmd_consume) rx_state_d = RX_IDLE;
      end
      RX_DATA_B: begin
        hin_canReceive = 1'b1;
        if (hin_isReady) begin
          word_d    = {word_q[55:0], hin};
          rx_bcnt_d = rx_bcnt_q + 3'd1;
          if (rx_bcnt_q == 3'd7) rx_state_d = RX_DATA_WAIT;
        end
      end
      RX_DATA_WAIT: begin
        in_isReady = 1'b1;
        if (in_canReceive) begin
          wcnt_d     = wcnt_q - 7'd1;
          rx_state_d = (wcnt_q == 7'd1) ? RX_IDLE : RX_DATA_B;
        end
      end
      RX_RD_ARM: begin
        // tcnt is only reloaded once TX has drained the previous READ.
        if (tcnt_q == 7'd0) begin
          tcnt_load  = 1'b1;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // TX: take one core word at a time while READ credit remains, emit MSB first.
  always_comb begin
    tx_state_d     = tx_state_q;
    sr_d           = sr_q;
    bcnt_d         = bcnt_q;
    tcnt_d         = tcnt_q;
    out_canReceive = 1'b0;
    hout_isReady   = 1'b0;
    hout           = 8'h00;
    unique case (tx_state_q)
      TX_IDLE: begin
        out_canReceive = (tcnt_q != 7'd0);
        if (out_canReceive && out_isReady) begin
          sr_d       = out;
          bcnt_d     = 4'd8;
          tcnt_d     = tcnt_q - 7'd1;
          tx_state_d = TX_SHIFT;
        end
      end
      TX_SHIFT: begin
        hout_isReady = 1'b1;
        hout         = sr_q[63:56];
        if (hout_canReceive) begin
          sr_d   = {sr_q[55:0], 8'h00};
          bcnt_d = bcnt_q - 4'd1;
          if (bcnt_q == 4'd1) tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // A load only happens at tcnt==0, when TX cannot be decrementing it.
    if (tcnt_load) tcnt_d = rd_n_q;
  end

  // Payload registers read as zero whenever their valid is low.
  assign cmd = cmd_hasAny ? cmd_q[CMD_W-1:0] : '0;
  assign in  = in_isReady ? word_q : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      cmd_q      <= '0;
      word_q     <= '0;
      rx_bcnt_q  <= '0;
      wcnt_q     <= '0;
      rd_n_q     <= '0;
      tx_state_q <= TX_IDLE;
      sr_q       <= '0;
      bcnt_q     <= '0;
      tcnt_q     <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      cmd_q      <= cmd_d;
      word_q     <= word_d;
      rx_bcnt_q  <= rx_bcnt_d;
      wcnt_q     <= wcnt_d;
      rd_n_q     <= rd_n_d;
      tx_state_q <= tx_state_d;
      sr_q       <= sr_d;
      bcnt_q     <= bcnt_d;
      tcnt_q     <= tcnt_d;
    end
  end

endmodule
